// File: rtl/hazard_sequencer_if.sv
// ---------------------------------------------------------------------------
// hazard_sequencer_if
// Bundles the signals exchanged between the hazard sequencer and the
// 5-stage RV32I pipeline.
//
// Pipeline -> sequencer:
//   id_rs1, id_rs2, id_opcode    ID-stage instruction fields
//   ex_mem_read, ex_rd           EX-stage load information
//   ex_branch_taken              branch/jump resolved taken in EX
//   mem_req, dmem_ready          data-memory request / completion handshake
// Sequencer -> pipeline:
//   pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall, exmem_stall
//   hz_state                     FSM state (RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3)
//   stall_cycles, flush_cycles   performance counters (zero unless enabled)
//
// Modports: master = pipeline side, slave = hazard sequencer side.
// ---------------------------------------------------------------------------
interface hazard_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [6:0]       id_opcode;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             dmem_ready;

    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             idex_stall;
    logic             exmem_stall;
    logic [1:0]       hz_state;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_cycles;

    modport master (
        output id_rs1, id_rs2, id_opcode, ex_mem_read, ex_rd,
               ex_branch_taken, mem_req, dmem_ready,
        input  pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall,
               exmem_stall, hz_state, stall_cycles, flush_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_opcode, ex_mem_read, ex_rd,
               ex_branch_taken, mem_req, dmem_ready,
        output pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall,
               exmem_stall, hz_state, stall_cycles, flush_cycles
    );
endinterface

// File: rtl/hazard_sequencer.sv
// ---------------------------------------------------------------------------
// hazard_sequencer
// Pipeline hazard controller for the 5-stage RV32I core. Sequences stall,
// bubble, flush and freeze controls for PC, IF/ID, ID/EX and EX/MEM so that
// load-use stalls, multi-cycle branch flushes and memory wait states never
// overlap or double-count.
//
// Ports:
//   clk   core clock
//   rst   asynchronous, active-high reset
//   hz    hazard_sequencer_if.slave (ID/EX hazard inputs, memory handshake,
//         pipeline control outputs, FSM state, performance counters)
//
// Parameters:
//   FLUSH_CYCLES  cycles of IF/ID flush + ID/EX bubble after a taken branch (1..7)
//   CNT_W         width of the performance counters
//
// Optional feature: define HAZARD_PERF_CNT_EN to build saturating
// stall_cycles / flush_cycles counters; otherwise both read as zero.
// ---------------------------------------------------------------------------
module hazard_sequencer #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst,
    hazard_sequencer_if.slave  hz
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } hz_state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    hz_state_t  state, next_state;
    logic [2:0] cnt, next_cnt;

    logic uses_rs1, uses_rs2, load_use, mem_busy;
    logic pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall, exmem_stall;

    // Decode which source registers the ID instruction actually reads, so
    // that immediate-only formats (LUI/AUIPC/JAL) never raise false hazards.
    always_comb begin
        uses_rs1 = !((hz.id_opcode == 7'b0110111) ||
                     (hz.id_opcode == 7'b0010111) ||
                     (hz.id_opcode == 7'b1101111));
        uses_rs2 =  (hz.id_opcode == 7'b0110011) ||
                    (hz.id_opcode == 7'b0100011) ||
                    (hz.id_opcode == 7'b1100011);
        load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                   ((uses_rs1 && (hz.ex_rd == hz.id_rs1)) ||
                    (uses_rs2 && (hz.ex_rd == hz.id_rs2)));
        mem_busy = hz.mem_req && !hz.dmem_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state and Mealy outputs. Memory freeze beats branch flush, which
    // beats load-use; LOAD_STALL masks load-use because its bubble is already
    // in ID/EX. Outputs are forced low while reset is held.
    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;

        case (state)
            RUN, LOAD_STALL: begin
                if (mem_busy) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                    next_state  = MEM_WAIT;
                end else if (hz.ex_branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        next_state = FLUSH;
                        next_cnt   = FLUSH_LOAD;
                    end else begin
                        next_state = RUN;
                    end
                end else if ((state == RUN) && load_use) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                    next_state  = LOAD_STALL;
                end else begin
                    next_state = RUN;
                end
            end
            FLUSH: begin
                // A memory wait freezes the flush in place; the count is held
                // so the remaining flush cycles resume afterwards.
                if (mem_busy) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                end else begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    next_cnt    = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        next_state = RUN;
                    end
                end
            end
            MEM_WAIT: begin
                if (!hz.dmem_ready) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                end else begin
                    next_state = RUN;
                end
            end
            default: next_state = RUN;
        endcase

        if (rst) begin
            pc_stall    = 1'b0;
            ifid_stall  = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            idex_stall  = 1'b0;
            exmem_stall = 1'b0;
        end
    end

    assign hz.pc_stall    = pc_stall;
    assign hz.ifid_stall  = ifid_stall;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_bubble = idex_bubble;
    assign hz.idex_stall  = idex_stall;
    assign hz.exmem_stall = exmem_stall;
    assign hz.hz_state    = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    // Flush cycles are not counted as stalls; both counters saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall && !ifid_flush && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ifid_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign hz.stall_cycles = stall_cnt;
    assign hz.flush_cycles = flush_cnt;
`else
    assign hz.stall_cycles = {CNT_W{1'b0}};
    assign hz.flush_cycles = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hazard_sequencer
// Directed self-checking bench for hazard_sequencer (FLUSH_CYCLES = 2).
// Inputs are driven on the falling clock edge and outputs sampled 1 ns later,
// well away from the rising edge that advances the FSM.
// ---------------------------------------------------------------------------
module tb_hazard_sequencer;

    localparam int CNT_W = 32;

    localparam logic [6:0] OP_ADD   = 7'b0110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    // Expected control word: {pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall, exmem_stall}
    localparam logic [5:0] C_NONE   = 6'b000000;
    localparam logic [5:0] C_LOAD   = 6'b110100;
    localparam logic [5:0] C_FLUSH  = 6'b001100;
    localparam logic [5:0] C_FREEZE = 6'b110011;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_LS   = 2'd1;
    localparam logic [1:0] S_FL   = 2'd2;
    localparam logic [1:0] S_MW   = 2'd3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hazard_sequencer_if #(.CNT_W(CNT_W)) hz ();

    hazard_sequencer #(
        .FLUSH_CYCLES (2),
        .CNT_W        (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] op,
                         input logic mr, input logic [4:0] rd, input logic br,
                         input logic mreq, input logic rdy);
        hz.id_rs1          = rs1;
        hz.id_rs2          = rs2;
        hz.id_opcode       = op;
        hz.ex_mem_read     = mr;
        hz.ex_rd           = rd;
        hz.ex_branch_taken = br;
        hz.mem_req         = mreq;
        hz.dmem_ready      = rdy;
    endtask

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] op,
                                 input logic mr, input logic [4:0] rd, input logic br,
                                 input logic mreq, input logic rdy);
        @(negedge clk);
        drive(rs1, rs2, op, mr, rd, br, mreq, rdy);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [5:0] exp_ctrl, input logic [1:0] exp_state);
        logic [7:0] observed;
        logic [7:0] expected;
        observed = {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_bubble,
                    hz.idex_stall, hz.exmem_stall, hz.hz_state};
        expected = {exp_ctrl, exp_state};
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed ctrl/state=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkCounters(input string tag, input int exp_stall, input int exp_flush);
        logic [2*CNT_W-1:0] observed;
        logic [2*CNT_W-1:0] expected;
        observed = {hz.stall_cycles, hz.flush_cycles};
`ifdef HAZARD_PERF_CNT_EN
        expected = {CNT_W'(exp_stall), CNT_W'(exp_flush)};
`else
        expected = '0;
        if (exp_stall < 0 || exp_flush < 0) expected = '1;
`endif
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed stall/flush=%0d/%0d expected=%0d/%0d", tag,
                   observed[2*CNT_W-1:CNT_W], observed[CNT_W-1:0],
                   expected[2*CNT_W-1:CNT_W], expected[CNT_W-1:0]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset held with a memory-busy and load-use pattern on the inputs:
        // every control output must stay low.
        rst = 1'b1;
        drive(5'd5, 5'd0, OP_ADD, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        #2;
        checkOutput("reset_gated", C_NONE, S_RUN);
        checkCounters("reset_counters", 0, 0);
        @(negedge clk);
        drive(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle", C_NONE, S_RUN);

        // Load-use on rs1: one stall cycle, then LOAD_STALL masks the same hazard.
        applyStimulus(5'd5, 5'd1, OP_ADD, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        checkOutput("loaduse_rs1", C_LOAD, S_RUN);
        applyStimulus(5'd5, 5'd1, OP_ADD, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        checkOutput("loadstall_masked", C_NONE, S_LS);
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("loaduse_return", C_NONE, S_RUN);

        // Load to x0 never stalls.
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("loaduse_x0", C_NONE, S_RUN);

        // rs2 hazard only counts for formats that read rs2.
        applyStimulus(5'd1, 5'd7, OP_IMM, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        checkOutput("itype_rs2_ignored", C_NONE, S_RUN);
        applyStimulus(5'd1, 5'd7, OP_STORE, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        checkOutput("store_rs2_hazard", C_LOAD, S_RUN);
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("store_loadstall", C_NONE, S_LS);

        // LUI with a matching rs1 field is not a hazard.
        applyStimulus(5'd5, 5'd0, OP_LUI, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        checkOutput("lui_no_hazard", C_NONE, S_RUN);
        applyStimulus(5'd5, 5'd0, OP_LUI, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        checkOutput("lui_stays_run", C_NONE, S_RUN);

        // Taken branch: two flush cycles, PC not stalled.
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("branch_cycle1", C_FLUSH, S_RUN);
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("branch_cycle2", C_FLUSH, S_FL);
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("branch_done", C_NONE, S_RUN);
        checkCounters("counters_after_branch", 2, 2);

        // Memory wait: three frozen cycles, then the ready cycle releases.
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("memwait_first", C_FREEZE, S_RUN);
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("memwait_second", C_FREEZE, S_MW);
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("memwait_third", C_FREEZE, S_MW);
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("memwait_ready", C_NONE, S_MW);
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("memwait_return", C_NONE, S_RUN);

        // All three events at once: freeze wins, branch beats load-use afterwards.
        applyStimulus(5'd5, 5'd0, OP_ADD, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        checkOutput("simul_freeze", C_FREEZE, S_RUN);
        applyStimulus(5'd5, 5'd0, OP_ADD, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
        checkOutput("simul_ready", C_NONE, S_MW);
        applyStimulus(5'd5, 5'd0, OP_ADD, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        checkOutput("simul_branch", C_FLUSH, S_RUN);
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("simul_flush2", C_FLUSH, S_FL);
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("simul_done", C_NONE, S_RUN);

        // Memory wait during FLUSH holds the remaining flush cycle.
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("flushhold_branch", C_FLUSH, S_RUN);
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("flushhold_freeze", C_FREEZE, S_FL);
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        checkOutput("flushhold_resume", C_FLUSH, S_FL);
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("flushhold_done", C_NONE, S_RUN);

        // Branch taken while in LOAD_STALL.
        applyStimulus(5'd9, 5'd0, OP_ADD, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        checkOutput("ls_branch_stall", C_LOAD, S_RUN);
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("ls_branch_flush", C_FLUSH, S_LS);
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("ls_branch_flush2", C_FLUSH, S_FL);
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("ls_branch_done", C_NONE, S_RUN);

        // Asynchronous reset mid-FLUSH, between clock edges.
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("midreset_branch", C_FLUSH, S_RUN);
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("midreset_inflush", C_FLUSH, S_FL);
        rst = 1'b1;
        #1;
        checkOutput("midreset_immediate", C_NONE, S_RUN);
        checkCounters("midreset_counters", 0, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(5'd0, 5'd0, OP_ADD, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("postreset_idle", C_NONE, S_RUN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
